// File: rtl/instr_fetch_buffer.sv
// Purpose : sequential instruction fetch, single-outstanding mem req/ack, DEPTH-entry prefetch FIFO.
// Latency : ack in cycle N into an empty buffer -> ir_valid/ir/ir_pc in cycle N+1.
// Backpres: a request issues only while buffered + outstanding < DEPTH; ir_ready low stalls fetch.
// Ports   : clk, rst_n; memory side mem_req/mem_addr/mem_ack/mem_rdata;
//           decode side ir_valid/ir/ir_pc/ir_ready; redirect flush/flush_pc.
// Option  : IFB_PREFETCH_ABORT_EN adds mem_abort (in, qualified by mem_ack) and ir_abort (out).
//           An aborted word travels with its entry and halts fetch until the next flush.
module instr_fetch_buffer #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ir_valid,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  input  logic        ir_ready,
  input  logic        flush,
  input  logic [31:0] flush_pc
`ifdef IFB_PREFETCH_ABORT_EN
  ,
  input  logic        mem_abort,
  output logic        ir_abort
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [31:0]   RST_PC = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t        state_q;
  logic [31:0]   fetch_pc_q;   // address currently (or next) presented on mem_addr
  logic [31:0]   redir_q;      // redirect target parked while draining
  logic          halt_q;       // set by an aborted fetch, cleared by flush
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;
  logic [AW-1:0] rd_q, wr_q, rd_nxt;
  logic [31:0]   dat_q [DEPTH];
  logic [31:0]   pc_q  [DEPTH];
  logic          push, pop, push_abt;
  logic [31:0]   tgt;
  logic          unused_ok;

  assign mem_addr  = fetch_pc_q;
  assign tgt       = {flush_pc[31:2], 2'b00};
  assign unused_ok = ^flush_pc[1:0];

`ifdef IFB_PREFETCH_ABORT_EN
  assign push_abt = mem_abort;
`else
  assign push_abt = 1'b0;
`endif

  // Only REQ has a request whose data is kept; a flush kills both sides.
  assign push    = mem_ack && (state_q == REQ) && !flush;
  assign pop     = ir_valid && ir_ready && !flush;
  assign cnt_nxt = cnt_q + CW'(push) - CW'(pop);
  assign rd_nxt  = rd_q + AW'(1);

  // Fetch FSM; mem_req is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_req    <= 1'b0;
      fetch_pc_q <= RST_PC;
      redir_q    <= RST_PC;
      halt_q     <= 1'b0;
    end else if (flush) begin
      halt_q  <= 1'b0;
      mem_req <= 1'b1;
      if (state_q != IDLE && !mem_ack) begin
        // Request still in flight: keep it stable, retarget after it returns.
        state_q <= DRAIN;
        redir_q <= tgt;
      end else begin
        state_q    <= REQ;
        fetch_pc_q <= tgt;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!halt_q && cnt_nxt < FULL) begin
            state_q <= REQ;
            mem_req <= 1'b1;
          end
        end
        REQ: begin
          if (mem_ack) begin
            fetch_pc_q <= fetch_pc_q + 32'd4;
            if (push_abt) begin
              halt_q  <= 1'b1;
              state_q <= IDLE;
              mem_req <= 1'b0;
            end else if (cnt_nxt >= FULL) begin
              // The next request would have no slot to land in.
              state_q <= IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            fetch_pc_q <= redir_q;
            state_q    <= REQ;
          end
        end
        default: begin
          state_q <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  // FIFO bookkeeping and the registered head (ir/ir_pc mirror the oldest entry).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      ir_valid <= 1'b0;
      ir       <= '0;
      ir_pc    <= '0;
    end else if (flush) begin
      cnt_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      ir_valid <= 1'b0;
    end else begin
      cnt_q    <= cnt_nxt;
      ir_valid <= (cnt_nxt != '0);
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_nxt;
      if (pop && cnt_q > CW'(1)) begin
        ir    <= dat_q[rd_nxt];
        ir_pc <= pc_q[rd_nxt];
      end else if (push && (cnt_q == '0 || (pop && cnt_q == CW'(1)))) begin
        // Pushed word becomes the head immediately.
        ir    <= mem_rdata;
        ir_pc <= fetch_pc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dat_q[wr_q] <= mem_rdata;
      pc_q[wr_q]  <= fetch_pc_q;
    end
  end

`ifdef IFB_PREFETCH_ABORT_EN
  logic abt_q [DEPTH];

  always_ff @(posedge clk) begin
    if (push) abt_q[wr_q] <= mem_abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_abort <= 1'b0;
    end else if (!flush) begin
      if (pop && cnt_q > CW'(1))
        ir_abort <= abt_q[rd_nxt];
      else if (push && (cnt_q == '0 || (pop && cnt_q == CW'(1))))
        ir_abort <= mem_abort;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Purpose : directed checks of instr_fetch_buffer (DEPTH=2, RESET_PC=0).
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpres: memory model returns mem_addr ^ KEY whenever the bench raises mem_ack.
module tb_instr_fetch_buffer;

  localparam logic [31:0] KEY = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req, mem_ack, ir_valid, ir_ready, flush;
  logic [31:0] mem_addr, mem_rdata, ir, ir_pc, flush_pc;
`ifdef IFB_PREFETCH_ABORT_EN
  logic        mem_abort, ir_abort;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr ^ KEY;

  instr_fetch_buffer #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .ir_ready(ir_ready),
    .flush(flush), .flush_pc(flush_pc)
`ifdef IFB_PREFETCH_ABORT_EN
    , .mem_abort(mem_abort), .ir_abort(ir_abort)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT one cycle after reset release: mem_req=1, mem_addr=0.
  task automatic do_reset();
    rst_n = 1'b0; mem_ack = 1'b0; ir_ready = 1'b0; flush = 1'b0; flush_pc = '0;
`ifdef IFB_PREFETCH_ABORT_EN
    mem_abort = 1'b0;
`endif
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ack = 1'b0; ir_ready = 1'b0; flush = 1'b0; flush_pc = '0;
`ifdef IFB_PREFETCH_ABORT_EN
    mem_abort = 1'b0;
`endif
    step(); step();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ir_valid); end
    checks++; if (ir !== 32'h0 || ir_pc !== 32'h0) begin errors++; $display("FAIL rst_ir: got %h/%h want 0/0", ir, ir_pc); end
`ifdef IFB_PREFETCH_ABORT_EN
    checks++; if (ir_abort !== 1'b0) begin errors++; $display("FAIL rst_abort: got %b want 0", ir_abort); end
`endif
    rst_n = 1'b1;
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL rel_req: got %b/%h want 1/0", mem_req, mem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL stream_v0: got %b want 0", ir_valid); end
    mem_ack = 1'b1; ir_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      exp_pc = 32'(4 * (k - 1));
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'(4 * k)) begin errors++; $display("FAIL stream_addr%0d: got %b/%h want 1/%h", k, mem_req, mem_addr, 32'(4 * k)); end
      checks++; if (ir_valid !== 1'b1 || ir_pc !== exp_pc) begin errors++; $display("FAIL stream_pc%0d: got %b/%h want 1/%h", k, ir_valid, ir_pc, exp_pc); end
      checks++; if (ir !== (exp_pc ^ KEY)) begin errors++; $display("FAIL stream_ir%0d: got %h want %h", k, ir, exp_pc ^ KEY); end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_ack = 1'b1; ir_ready = 1'b0;
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin errors++; $display("FAIL bp_req1: got %b/%h want 1/4", mem_req, mem_addr); end
    step();
    checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h8) begin errors++; $display("FAIL bp_stop: got %b/%h want 0/8", mem_req, mem_addr); end
    step();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_hold: got %b want 0", mem_req); end
    checks++; if (ir_valid !== 1'b1 || ir_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got %b/%h want 1/0", ir_valid, ir_pc); end
    ir_ready = 1'b1;
    step();
    checks++; if (ir_pc !== 32'h4 || ir !== (32'h4 ^ KEY)) begin errors++; $display("FAIL bp_pc4: got %h/%h want 4/%h", ir_pc, ir, 32'h4 ^ KEY); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin errors++; $display("FAIL bp_resume: got %b/%h want 1/8", mem_req, mem_addr); end
    step();
    checks++; if (ir_valid !== 1'b1 || ir_pc !== 32'h8) begin errors++; $display("FAIL bp_pc8: got %b/%h want 1/8", ir_valid, ir_pc); end
    mem_ack = 1'b0;
  endtask

  task automatic test_flush_drain();
    do_reset();
    mem_ack = 1'b1; ir_ready = 1'b1;
    step(); step();
    mem_ack = 1'b0; flush = 1'b1; flush_pc = 32'h0000_1003;
    step();
    flush = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin errors++; $display("FAIL drain_keep: got %b/%h want 1/8", mem_req, mem_addr); end
    checks++; if (ir_valid !== 1'b0 || ir_pc !== 32'h4) begin errors++; $display("FAIL drain_empty: got %b/%h want 0/4", ir_valid, ir_pc); end
    step(); step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin errors++; $display("FAIL drain_wait: got %b/%h want 1/8", mem_req, mem_addr); end
    mem_ack = 1'b1;
    step();
    checks++; if (mem_addr !== 32'h1000 || ir_valid !== 1'b0) begin errors++; $display("FAIL drain_redir: got %h/%b want 1000/0", mem_addr, ir_valid); end
    step();
    checks++; if (ir_valid !== 1'b1 || ir_pc !== 32'h1000 || ir !== (32'h1000 ^ KEY)) begin errors++; $display("FAIL drain_first: got %b/%h/%h want 1/1000/%h", ir_valid, ir_pc, ir, 32'h1000 ^ KEY); end
    mem_ack = 1'b0;
  endtask

  task automatic test_flush_ack();
    do_reset();
    mem_ack = 1'b1; ir_ready = 1'b1;
    step();
    flush = 1'b1; flush_pc = 32'h0000_2000;
    step();
    flush = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h2000) begin errors++; $display("FAIL fack_addr: got %b/%h want 1/2000", mem_req, mem_addr); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL fack_drop: got %b want 0", ir_valid); end
    step();
    checks++; if (ir_valid !== 1'b1 || ir_pc !== 32'h2000) begin errors++; $display("FAIL fack_next: got %b/%h want 1/2000", ir_valid, ir_pc); end
    mem_ack = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    flush = 1'b1; flush_pc = 32'hFFFF_FFF8;
    step();
    flush = 1'b0; mem_ack = 1'b1; ir_ready = 1'b1;
    step();
    checks++; if (mem_addr !== 32'hFFFF_FFF8 || ir_valid !== 1'b0) begin errors++; $display("FAIL wrap_tgt: got %h/%b want fffffff8/0", mem_addr, ir_valid); end
    step();
    checks++; if (ir_pc !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_pc0: got %h want fffffff8", ir_pc); end
    step();
    checks++; if (ir_pc !== 32'hFFFF_FFFC || mem_addr !== 32'h0) begin errors++; $display("FAIL wrap_pc1: got %h/%h want fffffffc/0", ir_pc, mem_addr); end
    step();
    checks++; if (ir_valid !== 1'b1 || ir_pc !== 32'h0 || ir !== KEY) begin errors++; $display("FAIL wrap_pc2: got %b/%h/%h want 1/0/%h", ir_valid, ir_pc, ir, KEY); end
    mem_ack = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_ack = 1'b1; ir_ready = 1'b1;
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL arst_req: got %b/%h want 0/0", mem_req, mem_addr); end
    checks++; if (ir_valid !== 1'b0 || ir !== 32'h0 || ir_pc !== 32'h0) begin errors++; $display("FAIL arst_ir: got %b/%h/%h want 0/0/0", ir_valid, ir, ir_pc); end
    rst_n = 1'b1;
    step();
    checks++; if (ir_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL arst_idle_ack: got %b/%b/%h want 0/1/0", ir_valid, mem_req, mem_addr); end
    mem_ack = 1'b0;
  endtask

`ifdef IFB_PREFETCH_ABORT_EN
  task automatic test_abort();
    do_reset();
    mem_ack = 1'b1; ir_ready = 1'b0;
    step();
    checks++; if (ir_abort !== 1'b0 || ir_pc !== 32'h0) begin errors++; $display("FAIL abt_good: got %b/%h want 0/0", ir_abort, ir_pc); end
    mem_abort = 1'b1;
    step();
    mem_abort = 1'b0; ir_ready = 1'b1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL abt_stop: got %b want 0", mem_req); end
    step();
    checks++; if (ir_pc !== 32'h4 || ir_abort !== 1'b1) begin errors++; $display("FAIL abt_flag: got %h/%b want 4/1", ir_pc, ir_abort); end
    step(); step();
    checks++; if (mem_req !== 1'b0 || ir_valid !== 1'b0) begin errors++; $display("FAIL abt_halt: got %b/%b want 0/0", mem_req, ir_valid); end
    flush = 1'b1; flush_pc = 32'h0000_0300;
    step();
    flush = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin errors++; $display("FAIL abt_restart: got %b/%h want 1/300", mem_req, mem_addr); end
    step();
    checks++; if (ir_valid !== 1'b1 || ir_pc !== 32'h300 || ir_abort !== 1'b0) begin errors++; $display("FAIL abt_clean: got %b/%h/%b want 1/300/0", ir_valid, ir_pc, ir_abort); end
    mem_ack = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_drain();
    test_flush_ack();
    test_wrap();
    test_async_reset();
`ifdef IFB_PREFETCH_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
